// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: handshake bundle between the UART receiver, the byte FIFO
// and the CPU memory-map read path.
//   in_data/in_valid/in_ready     : byte stream from the UART receiver
//   out_data/out_valid/out_ready  : first-word-fall-through head toward the CPU
//   count/overflow/clr_overflow   : occupancy and sticky drop flag for status reg
// master = producer/consumer side (receiver + CPU), slave = the FIFO.
interface uart_rx_fifo_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clr_overflow;

   modport master (
      output in_data, in_valid, out_ready, clr_overflow,
      input  in_ready, out_data, out_valid, count, overflow
   );

   modport slave (
      input  in_data, in_valid, out_ready, clr_overflow,
      output in_ready, out_data, out_valid, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO buffering UART receive data for a polling CPU.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset (pointers, count, overflow)
//   bus  : uart_rx_fifo_if.slave (in/out handshakes, count, overflow, clr)
// Parameters:
//   DEPTH        : entries, power of two >= 2
//   DROP_ON_FULL : 1 = always ready, drop when full and flag overflow;
//                  0 = deassert in_ready when full
module uart_rx_fifo #(
   parameter int unsigned DEPTH        = 8,
   parameter bit          DROP_ON_FULL = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_fifo_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full_c;
   logic          push_c;
   logic          pop_c;

   // Next-state: full check uses the pre-edge count, so a pop cannot free a
   // slot for a push in the same cycle.
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      full_c     = (count_q == CW'(DEPTH));
      push_c     = bus.in_valid & ~full_c;
      pop_c      = bus.out_ready & (count_q != '0);

      if (push_c) wptr_d = wptr_q + AW'(1);
      if (pop_c)  rptr_d = rptr_q + AW'(1);

      if (push_c & ~pop_c)      count_d = count_q + CW'(1);
      else if (pop_c & ~push_c) count_d = count_q - CW'(1);

      // Set beats clear when both happen in one cycle.
      if (DROP_ON_FULL & bus.in_valid & full_c) overflow_d = 1'b1;
      else if (bus.clr_overflow)                overflow_d = 1'b0;
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array; contents are never reset.
   always_ff @(posedge clk) begin
      if (!rst && push_c) mem_q[wptr_q] <= bus.in_data;
   end

   // Status and head outputs derive from registered state only.
   assign bus.in_ready  = DROP_ON_FULL ? 1'b1 : ~full_c;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem_q[rptr_q];
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives a drop-on-full and a backpressure FIFO with the same
// stimulus and compares both against queue-based reference models.
module tb_uart_rx_fifo;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus_d ();
   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus_b ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) dut_d (
      .clk (clk),
      .rst (rst),
      .bus (bus_d)
   );

   uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   logic [7:0] mq_d [$];
   logic [7:0] mq_b [$];
   bit         ovf_d = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour: queue semantics with pre-edge full test.
   task automatic model_update(input bit r, input bit iv, input logic [7:0] id,
                               input bit ordy, input bit clr);
      bit full;
      if (r) begin
         mq_d.delete();
         mq_b.delete();
         ovf_d = 1'b0;
      end else begin
         full = (mq_d.size() == DEPTH);
         if (iv && full) ovf_d = 1'b1;
         else if (clr)   ovf_d = 1'b0;
         if (ordy && mq_d.size() != 0) void'(mq_d.pop_front());
         if (iv && !full) mq_d.push_back(id);

         full = (mq_b.size() == DEPTH);
         if (ordy && mq_b.size() != 0) void'(mq_b.pop_front());
         if (iv && !full) mq_b.push_back(id);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, " d.count"}, 32'(bus_d.count), 32'(mq_d.size()));
      chk({ph, " d.out_valid"}, 32'(bus_d.out_valid), 32'(mq_d.size() != 0));
      if (mq_d.size() != 0) chk({ph, " d.out_data"}, 32'(bus_d.out_data), 32'(mq_d[0]));
      chk({ph, " d.overflow"}, 32'(bus_d.overflow), 32'(ovf_d));
      chk({ph, " d.in_ready"}, 32'(bus_d.in_ready), 32'd1);
      chk({ph, " b.count"}, 32'(bus_b.count), 32'(mq_b.size()));
      chk({ph, " b.out_valid"}, 32'(bus_b.out_valid), 32'(mq_b.size() != 0));
      if (mq_b.size() != 0) chk({ph, " b.out_data"}, 32'(bus_b.out_data), 32'(mq_b[0]));
      chk({ph, " b.overflow"}, 32'(bus_b.overflow), 32'd0);
      chk({ph, " b.in_ready"}, 32'(bus_b.in_ready), 32'(mq_b.size() != DEPTH));
   endtask

   // One clock: drive on negedge, model at the edge, check 1 time unit later.
   task automatic cycle(input string ph, input bit r, input bit iv, input logic [7:0] id,
                        input bit ordy, input bit clr);
      @(negedge clk);
      rst                = r;
      bus_d.in_valid     = iv;
      bus_b.in_valid     = iv;
      bus_d.in_data      = id;
      bus_b.in_data      = id;
      bus_d.out_ready    = ordy;
      bus_b.out_ready    = ordy;
      bus_d.clr_overflow = clr;
      bus_b.clr_overflow = clr;
      @(posedge clk);
      model_update(r, iv, id, ordy, clr);
      #1;
      check_all(ph);
   endtask

   initial begin
      logic [7:0] d;
      bus_d.in_valid = 1'b0; bus_b.in_valid = 1'b0;
      bus_d.in_data = 8'h00; bus_b.in_data = 8'h00;
      bus_d.out_ready = 1'b0; bus_b.out_ready = 1'b0;
      bus_d.clr_overflow = 1'b0; bus_b.clr_overflow = 1'b0;

      // Reset then in-order push/pop of three bytes.
      cycle("rst", 1, 0, 8'h00, 0, 0);
      cycle("rst", 1, 0, 8'h00, 0, 0);
      cycle("t1", 0, 1, 8'h41, 0, 0);
      cycle("t1", 0, 1, 8'h42, 0, 0);
      cycle("t1", 0, 1, 8'h43, 0, 0);
      chk("t1 head const", 32'(bus_d.out_data), 32'h41);
      chk("t1 count const", 32'(bus_d.count), 32'd3);
      for (int i = 0; i < 3; i++) cycle("t1 pop", 0, 0, 8'h00, 1, 0);
      chk("t1 empty const", 32'(bus_d.out_valid), 32'd0);

      // Fill, drop/hold the ninth byte, then full-with-pop and clear races.
      for (int i = 0; i < 9; i++) cycle("t2 fill", 0, 1, 8'(i), 0, 0);
      chk("t2 overflow const", 32'(bus_d.overflow), 32'd1);
      chk("t3 in_ready const", 32'(bus_b.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) cycle("t3 hold", 0, 1, 8'h55, 0, 0);
      cycle("t5 full pop", 0, 1, 8'h55, 1, 0);
      chk("t5 full pop count", 32'(bus_d.count), 32'd7);
      chk("t3 ready after pop", 32'(bus_b.in_ready), 32'd1);
      cycle("t3 accept", 0, 1, 8'h55, 0, 0);
      chk("t3 count const", 32'(bus_b.count), 32'd8);
      cycle("t5 clr+drop", 0, 1, 8'h66, 0, 1);
      chk("t5 set wins", 32'(bus_d.overflow), 32'd1);
      cycle("t2 clr", 0, 0, 8'h00, 0, 1);
      chk("t2 cleared", 32'(bus_d.overflow), 32'd0);
      for (int i = 0; i < 8; i++) cycle("t2 drain", 0, 0, 8'h00, 1, 0);

      // Empty with simultaneous push and pop: only the push lands.
      cycle("t5 empty", 0, 1, 8'h77, 1, 0);
      chk("t5 empty head", 32'(bus_d.out_data), 32'h77);
      cycle("t5 drain", 0, 0, 8'h00, 1, 0);

      // Steady-state stream at occupancy 2 to exercise pointer wrap.
      cycle("t4 pre", 0, 1, 8'h10, 0, 0);
      cycle("t4 pre", 0, 1, 8'h11, 0, 0);
      for (int i = 0; i < 20; i++) cycle("t4 wrap", 0, 1, 8'(8'h12 + i), 1, 0);
      chk("t4 count const", 32'(bus_d.count), 32'd2);
      for (int i = 0; i < 2; i++) cycle("t4 drain", 0, 0, 8'h00, 1, 0);

      // Reset mid-stream with count 5, overflow set, and in_valid high.
      for (int i = 0; i < 9; i++) cycle("t6 fill", 0, 1, 8'(8'h80 + i), 0, 0);
      for (int i = 0; i < 3; i++) cycle("t6 pop", 0, 0, 8'h00, 1, 0);
      chk("t6 pre count", 32'(bus_d.count), 32'd5);
      cycle("t6 rst", 1, 1, 8'hEE, 0, 0);
      chk("t6 post count", 32'(bus_d.count), 32'd0);
      chk("t6 post ovf", 32'(bus_d.overflow), 32'd0);
      cycle("t6 idle", 0, 0, 8'h00, 0, 0);

      // Random traffic, with occasional clears and resets.
      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         cycle("rand", ($urandom_range(63) == 0), ($urandom_range(99) < 60), d,
               ($urandom_range(99) < 45), ($urandom_range(15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
